l15_req_arbiter: RTL and testbench

Sequential round-robin arbiter that merges channel-1 requests from the four L1.5 caches onto the single L2 request channel. Each core has a one-entry holding slot with a valid/ready handshake. A registered output stage drives `msg1_*` with valid/ready and reports the winning core in `msg1_source`. It sits between the four `l15` instances and the L2 input, and replaces combinational per-cycle selection with buffered, back-pressurable arbitration.

---
 rtl/l15_req_arbiter.sv | 178 +++++++++++++++++
 tb/tb_l15_req_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/l15_req_arbiter.sv
// Round-robin merge of the four L1.5 channel-1 request streams onto the single L2 request
// channel. Each core has a one-entry holding slot, and the output is a registered,
// back-pressurable message stage.
`ifndef MSG_WIDTH
`define MSG_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 8
`endif
`ifndef OWNER_BITS
`define OWNER_BITS 6
`endif
`ifndef MSG_TYPE_EMPTY
`define MSG_TYPE_EMPTY 8'd0
`endif

module l15_req_arbiter #(
    parameter int MSG_W  = `MSG_WIDTH,
    parameter int DATA_W = `DATA_WIDTH,
    parameter int TAG_W  = `TAG_WIDTH,
    parameter int SRC_W  = `OWNER_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [3:0]            req_valid_i,
    output logic [3:0]            req_ready_o,
    input  logic [4*MSG_W-1:0]    req_type_i,
    input  logic [4*DATA_W-1:0]   req_data_i,
    input  logic [4*TAG_W-1:0]    req_tag_i,
    output logic                  msg1_valid_o,
    input  logic                  msg1_ready_i,
    output logic [MSG_W-1:0]      msg1_type_o,
    output logic [DATA_W-1:0]     msg1_data_o,
    output logic [TAG_W-1:0]      msg1_tag_o,
    output logic [SRC_W-1:0]      msg1_source_o,
    output logic [3:0]            pending_o
);

    localparam logic [MSG_W-1:0] EMPTY_TYPE = MSG_W'(`MSG_TYPE_EMPTY);

    logic [3:0]        slot_full;
    logic [MSG_W-1:0]  slot_type [4];
    logic [DATA_W-1:0] slot_data [4];
    logic [TAG_W-1:0]  slot_tag  [4];

    logic [1:0]        ptr_q, ptr_d;
    logic              msg1_valid_q, msg1_valid_d;
    logic [MSG_W-1:0]  msg1_type_q, msg1_type_d;
    logic [DATA_W-1:0] msg1_data_q, msg1_data_d;
    logic [TAG_W-1:0]  msg1_tag_q, msg1_tag_d;
    logic [SRC_W-1:0]  msg1_source_q, msg1_source_d;

    logic       out_free;
    logic       grant;
    logic       win_found;
    logic [1:0] win_idx;

    assign out_free = !msg1_valid_q || msg1_ready_i;
    assign grant    = out_free && win_found;

    // Scanning from ptr+3 down to ptr leaves the first full slot (in rotation order) as winner.
    always_comb begin
        logic [1:0] idx;
        idx       = '0;
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (slot_full[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            logic              full_q, full_d;
            logic [MSG_W-1:0]  type_q, type_d;
            logic [DATA_W-1:0] data_q, data_d;
            logic [TAG_W-1:0]  tag_q, tag_d;
            logic              load;
            logic              clear;

            // A slot never loads and drains in the same cycle: ready is the registered ~full.
            assign load  = req_valid_i[gi] && !full_q
                           && (req_type_i[gi*MSG_W +: MSG_W] != EMPTY_TYPE);
            assign clear = grant && (win_idx == 2'(gi));

            always_comb begin
                full_d = full_q;
                type_d = type_q;
                data_d = data_q;
                tag_d  = tag_q;
                if (load) begin
                    full_d = 1'b1;
                    type_d = req_type_i[gi*MSG_W +: MSG_W];
                    data_d = req_data_i[gi*DATA_W +: DATA_W];
                    tag_d  = req_tag_i[gi*TAG_W +: TAG_W];
                end else if (clear) begin
                    full_d = 1'b0;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    full_q <= 1'b0;
                    type_q <= EMPTY_TYPE;
                    data_q <= '0;
                    tag_q  <= '0;
                end else begin
                    full_q <= full_d;
                    type_q <= type_d;
                    data_q <= data_d;
                    tag_q  <= tag_d;
                end
            end

            assign slot_full[gi] = full_q;
            assign slot_type[gi] = type_q;
            assign slot_data[gi] = data_q;
            assign slot_tag[gi]  = tag_q;
        end
    endgenerate

    always_comb begin
        ptr_d         = ptr_q;
        msg1_valid_d  = msg1_valid_q;
        msg1_type_d   = msg1_type_q;
        msg1_data_d   = msg1_data_q;
        msg1_tag_d    = msg1_tag_q;
        msg1_source_d = msg1_source_q;
        if (out_free) begin
            if (win_found) begin
                msg1_valid_d  = 1'b1;
                msg1_type_d   = slot_type[win_idx];
                msg1_data_d   = slot_data[win_idx];
                msg1_tag_d    = slot_tag[win_idx];
                msg1_source_d = SRC_W'(win_idx);
                ptr_d         = win_idx + 2'd1;
            end else begin
                msg1_valid_d  = 1'b0;
                msg1_type_d   = EMPTY_TYPE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q         <= 2'd0;
            msg1_valid_q  <= 1'b0;
            msg1_type_q   <= EMPTY_TYPE;
            msg1_data_q   <= '0;
            msg1_tag_q    <= '0;
            msg1_source_q <= '0;
        end else begin
            ptr_q         <= ptr_d;
            msg1_valid_q  <= msg1_valid_d;
            msg1_type_q   <= msg1_type_d;
            msg1_data_q   <= msg1_data_d;
            msg1_tag_q    <= msg1_tag_d;
            msg1_source_q <= msg1_source_d;
        end
    end

    assign req_ready_o   = ~slot_full;
    assign pending_o     = slot_full;
    assign msg1_valid_o  = msg1_valid_q;
    assign msg1_type_o   = msg1_type_q;
    assign msg1_data_o   = msg1_data_q;
    assign msg1_tag_o    = msg1_tag_q;
    assign msg1_source_o = msg1_source_q;

endmodule

// File: tb/tb_l15_req_arbiter.sv
// Directed bench for l15_req_arbiter: a per-cycle vector table plus hand sequences
// for reset behaviour and single-request latency.
module tb_l15_req_arbiter;

    localparam int MSG_W  = 8;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 8;
    localparam int SRC_W  = 6;
    localparam logic [7:0] T_EMPTY = 8'd0;
    localparam logic [7:0] T_LOAD  = 8'd31;
    localparam logic [7:0] T_STORE = 8'd32;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic [3:0]          req_valid_i = '0;
    logic [3:0]          req_ready_o;
    logic [4*MSG_W-1:0]  req_type_i = '0;
    logic [4*DATA_W-1:0] req_data_i = '0;
    logic [4*TAG_W-1:0]  req_tag_i = '0;
    logic                msg1_valid_o;
    logic                msg1_ready_i = 1'b1;
    logic [MSG_W-1:0]    msg1_type_o;
    logic [DATA_W-1:0]   msg1_data_o;
    logic [TAG_W-1:0]    msg1_tag_o;
    logic [SRC_W-1:0]    msg1_source_o;
    logic [3:0]          pending_o;

    int tests = 0;
    int fails = 0;

    l15_req_arbiter #(
        .MSG_W(MSG_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .SRC_W(SRC_W)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_type_i(req_type_i), .req_data_i(req_data_i), .req_tag_i(req_tag_i),
        .msg1_valid_o(msg1_valid_o), .msg1_ready_i(msg1_ready_i),
        .msg1_type_o(msg1_type_o), .msg1_data_o(msg1_data_o), .msg1_tag_o(msg1_tag_o),
        .msg1_source_o(msg1_source_o), .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] emp;
        logic [7:0] tb;
        logic       rdy;
        logic       e_v;
        logic [1:0] e_src;
        logic [7:0] e_tag;
        logic [3:0] e_pend;
        logic [1:0] e_ptr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] emp, input logic [7:0] tb,
                                input logic rdy, input logic ev, input logic [1:0] es,
                                input logic [7:0] et, input logic [3:0] ep, input logic [1:0] eptr);
        vec_t v;
        v.vld = vld; v.emp = emp; v.tb = tb; v.rdy = rdy;
        v.e_v = ev; v.e_src = es; v.e_tag = et; v.e_pend = ep; v.e_ptr = eptr;
        return v;
    endfunction

    function automatic logic [7:0] typ_of(input int c);
        return (c % 2 == 1) ? T_STORE : T_LOAD;
    endfunction

    function automatic logic [63:0] dat(input logic [7:0] t);
        return {56'hDA7A_0000_0000_00, t};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] vld, input logic [3:0] emp, input logic [7:0] tb);
        for (int i = 0; i < 4; i++) begin
            req_valid_i[i]              = vld[i];
            req_type_i[i*MSG_W +: MSG_W] = emp[i] ? T_EMPTY : typ_of(i);
            req_tag_i[i*TAG_W +: TAG_W]  = tb + 8'(i);
            req_data_i[i*DATA_W +: DATA_W] = dat(tb + 8'(i));
        end
    endtask

    task automatic chk_out(input string nm, input logic ev, input logic [1:0] es,
                           input logic [7:0] et, input logic [3:0] ep, input logic [1:0] eptr);
        logic [3:0] erdy;
        erdy = ~ep;
        chk({nm, ".valid"}, 64'(msg1_valid_o), 64'(ev));
        if (ev) begin
            chk({nm, ".source"}, 64'(msg1_source_o), 64'(es));
            chk({nm, ".tag"}, 64'(msg1_tag_o), 64'(et));
            chk({nm, ".data"}, msg1_data_o, dat(et));
            chk({nm, ".type"}, 64'(msg1_type_o), 64'(typ_of(int'(es))));
        end else begin
            chk({nm, ".type"}, 64'(msg1_type_o), 64'(T_EMPTY));
        end
        chk({nm, ".pending"}, 64'(pending_o), 64'(ep));
        chk({nm, ".req_ready"}, 64'(req_ready_o), 64'(erdy));
        chk({nm, ".ptr"}, 64'(dut.ptr_q), 64'(eptr));
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, ".valid"}, 64'(msg1_valid_o), 64'd0);
        chk({nm, ".type"}, 64'(msg1_type_o), 64'(T_EMPTY));
        chk({nm, ".data"}, msg1_data_o, 64'd0);
        chk({nm, ".tag"}, 64'(msg1_tag_o), 64'd0);
        chk({nm, ".source"}, 64'(msg1_source_o), 64'd0);
        chk({nm, ".pending"}, 64'(pending_o), 64'd0);
        chk({nm, ".req_ready"}, 64'(req_ready_o), 64'hF);
        chk({nm, ".ptr"}, 64'(dut.ptr_q), 64'd0);
    endtask

    initial begin
        // vld, emp, tag_base, rdy | exp valid, src, tag, pending, ptr
        vq.push_back(mk(4'b1111, 4'b0000, 8'h10, 1, 0, 0, 8'h00, 4'b1111, 0)); // round-robin
        vq.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 1, 0, 8'h10, 4'b1110, 1));
        vq.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 1, 1, 8'h11, 4'b1100, 2));
        vq.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 1, 2, 8'h12, 4'b1000, 3));
        vq.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 1, 3, 8'h13, 4'b0000, 0));
        vq.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 0, 0, 8'h00, 4'b0000, 0));
        vq.push_back(mk(4'b1010, 4'b0000, 8'h20, 1, 0, 0, 8'h00, 4'b1010, 0)); // back-pressure
        vq.push_back(mk(4'b0000, 4'b0000, 8'h00, 0, 1, 1, 8'h21, 4'b1000, 2));
        vq.push_back(mk(4'b0010, 4'b0000, 8'h30, 0, 1, 1, 8'h21, 4'b1010, 2));
        vq.push_back(mk(4'b1010, 4'b0000, 8'h40, 0, 1, 1, 8'h21, 4'b1010, 2));
        vq.push_back(mk(4'b1010, 4'b0000, 8'h40, 0, 1, 1, 8'h21, 4'b1010, 2));
        vq.push_back(mk(4'b1010, 4'b0000, 8'h40, 0, 1, 1, 8'h21, 4'b1010, 2));
        vq.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 1, 3, 8'h23, 4'b0010, 0));
        vq.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 1, 1, 8'h31, 4'b0000, 2));
        vq.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 0, 0, 8'h00, 4'b0000, 2));
        vq.push_back(mk(4'b0001, 4'b0001, 8'h00, 1, 0, 0, 8'h00, 4'b0000, 2)); // EMPTY filtering
        vq.push_back(mk(4'b0001, 4'b0001, 8'h00, 1, 0, 0, 8'h00, 4'b0000, 2));
        vq.push_back(mk(4'b0011, 4'b0001, 8'h50, 1, 0, 0, 8'h00, 4'b0010, 2));
        vq.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 1, 1, 8'h51, 4'b0000, 2));
        vq.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 0, 0, 8'h00, 4'b0000, 2));
        vq.push_back(mk(4'b0100, 4'b0000, 8'h60, 1, 0, 0, 8'h00, 4'b0100, 2)); // drain-cycle ready=0
        vq.push_back(mk(4'b0100, 4'b0000, 8'h70, 1, 1, 2, 8'h62, 4'b0000, 3));
        vq.push_back(mk(4'b0100, 4'b0000, 8'h80, 1, 0, 0, 8'h00, 4'b0100, 3));
        vq.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 1, 2, 8'h82, 4'b0000, 3));

        // Reset held with all cores requesting: nothing may load.
        rst_ni = 1'b0;
        msg1_ready_i = 1'b1;
        drive(4'b1111, 4'b0000, 8'h01);
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_state("reset_hold");
        $display("[TB] reset hold: valid=%0b pending=%b ready=%b", msg1_valid_o, pending_o, req_ready_o);
        rst_ni = 1'b1;
        drive(4'b0000, 4'b0000, 8'h00);
        #1;
        chk("reset_release.req_ready", 64'(req_ready_o), 64'hF);

        foreach (vq[n]) begin
            drive(vq[n].vld, vq[n].emp, vq[n].tb);
            msg1_ready_i = vq[n].rdy;
            @(posedge clk_i);
            #1;
            chk_out($sformatf("vec%0d", n), vq[n].e_v, vq[n].e_src, vq[n].e_tag,
                    vq[n].e_pend, vq[n].e_ptr);
            $display("[TB] vec %0d: valid=%0b src=%0d tag=0x%0h pending=%b ptr=%0d",
                     n, msg1_valid_o, msg1_source_o, msg1_tag_o, pending_o, dut.ptr_q);
        end

        // Output held (core 2 message) while three new slots fill, then async reset mid-cycle.
        drive(4'b1110, 4'b0000, 8'h90);
        msg1_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk_out("midrst_pre", 1'b1, 2'd2, 8'h82, 4'b1110, 2'd3);
        $display("[TB] mid-reset setup: valid=%0b pending=%b", msg1_valid_o, pending_o);
        #2;
        rst_ni = 1'b0;
        drive(4'b1111, 4'b0000, 8'hA0);
        #1;
        chk_reset_state("midrst_async");
        @(posedge clk_i);
        #1;
        chk_reset_state("midrst_edge");
        rst_ni = 1'b1;
        drive(4'b0000, 4'b0000, 8'h00);
        msg1_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("midrst_after%0d.valid", c), 64'(msg1_valid_o), 64'd0);
            chk($sformatf("midrst_after%0d.pending", c), 64'(pending_o), 64'd0);
            $display("[TB] post-reset cycle %0d: valid=%0b pending=%b", c, msg1_valid_o, pending_o);
        end

        // Single request: core 2, LOAD, tag 5, data 0xA, from ptr 0.
        req_valid_i = 4'b0100;
        req_type_i[2*MSG_W +: MSG_W]   = T_LOAD;
        req_tag_i[2*TAG_W +: TAG_W]    = 8'd5;
        req_data_i[2*DATA_W +: DATA_W] = 64'hA;
        @(posedge clk_i);
        #1;
        chk("single_e0.valid", 64'(msg1_valid_o), 64'd0);
        chk("single_e0.pending", 64'(pending_o), 64'h4);
        req_valid_i = 4'b0000;
        @(posedge clk_i);
        #1;
        chk("single_e1.valid", 64'(msg1_valid_o), 64'd1);
        chk("single_e1.source", 64'(msg1_source_o), 64'd2);
        chk("single_e1.tag", 64'(msg1_tag_o), 64'd5);
        chk("single_e1.data", msg1_data_o, 64'hA);
        chk("single_e1.type", 64'(msg1_type_o), 64'(T_LOAD));
        $display("[TB] single: valid=%0b src=%0d tag=%0d data=0x%0h", msg1_valid_o, msg1_source_o,
                 msg1_tag_o, msg1_data_o);
        @(posedge clk_i);
        #1;
        chk("single_e2.valid", 64'(msg1_valid_o), 64'd0);
        chk("single_e2.type", 64'(msg1_type_o), 64'(T_EMPTY));
        chk("single_e2.ptr", 64'(dut.ptr_q), 64'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
